// File: rtl/rob_multi_commit_pkg.sv
// Shared types and helpers for the reorder buffer.
// Entry layout plus modular pointer arithmetic.
package rob_pkg;
    localparam int ROB_XLEN  = 32;
    localparam int ROB_DEPTH = 16;

    typedef struct packed {
        logic                busy;
        logic                done;
        logic [4:0]          rd;
        logic [ROB_XLEN-1:0] data;
    } rob_entry_t;

    function automatic int unsigned rob_ptr_add(
        input int unsigned ptr,
        input int unsigned n,
        input int unsigned depth = ROB_DEPTH
    );
        return (ptr + n) % depth;
    endfunction
endpackage

// File: rtl/rob_multi_commit_if.sv
// Dispatch / CDB / commit bundle of the reorder buffer.
// Perf counter signals exist only when ROB_PERF_EN is defined.
interface rob_multi_commit_if #(
    parameter int DEPTH     = 16,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int CDB_PORTS = 2,
    parameter int COMMIT_W  = 2,
    parameter int XLEN      = 32
);
    logic                                alloc_valid;
    logic [4:0]                          alloc_rd;
    logic                                alloc_ready;
    logic [IDX_W-1:0]                    alloc_tag;
    logic [CDB_PORTS-1:0]                cdb_valid;
    logic [CDB_PORTS-1:0][IDX_W-1:0]     cdb_tag;
    logic [CDB_PORTS-1:0][XLEN-1:0]      cdb_data;
    logic [IDX_W-1:0]                    src_tag;
    logic                                src_ready;
    logic [XLEN-1:0]                     src_data;
    logic [COMMIT_W-1:0]                 commit_valid;
    logic [COMMIT_W-1:0]                 commit_we;
    logic [COMMIT_W-1:0][4:0]            commit_rd;
    logic [COMMIT_W-1:0][XLEN-1:0]       commit_data;
    logic [COMMIT_W-1:0][IDX_W-1:0]      commit_tag;
    logic                                flush;
    logic [IDX_W:0]                      count;
`ifdef ROB_PERF_EN
    logic [31:0]                         perf_full_cycles;
    logic [31:0]                         perf_commits;
    logic [31:0]                         perf_flushes;
`endif

    modport master (
        output alloc_valid, alloc_rd,
        output cdb_valid, cdb_tag, cdb_data,
        output src_tag, flush,
        input  alloc_ready, alloc_tag,
        input  src_ready, src_data,
        input  commit_valid, commit_we,
        input  commit_rd, commit_data, commit_tag,
`ifdef ROB_PERF_EN
        input  perf_full_cycles, perf_commits,
        input  perf_flushes,
`endif
        input  count
    );

    modport slave (
        input  alloc_valid, alloc_rd,
        input  cdb_valid, cdb_tag, cdb_data,
        input  src_tag, flush,
        output alloc_ready, alloc_tag,
        output src_ready, src_data,
        output commit_valid, commit_we,
        output commit_rd, commit_data, commit_tag,
`ifdef ROB_PERF_EN
        output perf_full_cycles, perf_commits,
        output perf_flushes,
`endif
        output count
    );
endinterface

// File: rtl/rob_multi_commit_commit_scan.sv
// Finds the run of busy+done entries starting at head,
// capped at COMMIT_W, as a slot mask plus its length.
module rob_commit_scan
    import rob_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int COMMIT_W = 2
) (
    input  logic [IDX_W-1:0]    i_head,
    input  logic [DEPTH-1:0]    i_busy,
    input  logic [DEPTH-1:0]    i_done,
    output logic [COMMIT_W-1:0] o_mask,
    output logic [IDX_W:0]      o_ncommit
);
    logic [IDX_W-1:0] w_idx;
    logic             w_run;

    always_comb begin
        w_idx     = i_head;
        w_run     = 1'b1;
        o_mask    = '0;
        o_ncommit = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            w_idx = IDX_W'(rob_ptr_add(
                32'(i_head), unsigned'(k), DEPTH));
            w_run     = w_run & i_busy[w_idx] & i_done[w_idx];
            o_mask[k] = w_run;
            o_ncommit = o_ncommit + (IDX_W+1)'(w_run);
        end
    end
endmodule

// File: rtl/rob_multi_commit.sv
// Multi-commit reorder buffer with CDB capture and operand bypass.
// Optional perf counters: define ROB_PERF_EN.
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int CDB_PORTS = 2,
    parameter int COMMIT_W  = 2,
    parameter int XLEN      = 32
) (
    input logic               clk,
    input logic               rst,
    rob_multi_commit_if.slave bus
);
    rob_entry_t       r_entry [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    logic [DEPTH-1:0]    w_busy;
    logic [DEPTH-1:0]    w_done;
    logic [COMMIT_W-1:0] w_mask;
    logic [COMMIT_W-1:0] w_commit;
    logic [IDX_W:0]      w_ncommit;
    logic [IDX_W:0]      w_nretire;
    logic                w_alloc_fire;
    logic [IDX_W-1:0]    w_cidx [COMMIT_W];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_busy[i] = r_entry[i].busy;
            w_done[i] = r_entry[i].done;
        end
    end

    rob_commit_scan #(
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .COMMIT_W (COMMIT_W)
    ) u_scan (
        .i_head    (r_head),
        .i_busy    (w_busy),
        .i_done    (w_done),
        .o_mask    (w_mask),
        .o_ncommit (w_ncommit)
    );

    // Flush suppresses retirement in its own cycle.
    assign w_commit  = bus.flush ? '0 : w_mask;
    assign w_nretire = bus.flush ? '0 : w_ncommit;

    assign bus.alloc_ready = (r_count != (IDX_W+1)'(DEPTH));
    assign bus.alloc_tag   = r_tail;
    assign bus.count       = r_count;
    assign w_alloc_fire    = bus.alloc_valid & bus.alloc_ready;

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            w_cidx[k] = IDX_W'(rob_ptr_add(
                32'(r_head), unsigned'(k), DEPTH));
        end
    end

    always_comb begin
        bus.commit_valid = w_commit;
        bus.commit_we    = '0;
        bus.commit_rd    = '0;
        bus.commit_data  = '0;
        bus.commit_tag   = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            bus.commit_rd[k]   = r_entry[w_cidx[k]].rd;
            bus.commit_data[k] = XLEN'(r_entry[w_cidx[k]].data);
            bus.commit_tag[k]  = w_cidx[k];
            bus.commit_we[k]   = w_commit[k]
                & (r_entry[w_cidx[k]].rd != 5'd0);
        end
    end

    // Captured data wins; else the lowest matching CDB port.
    always_comb begin
        bus.src_ready = r_entry[bus.src_tag].done;
        bus.src_data  = XLEN'(r_entry[bus.src_tag].data);
        if (!r_entry[bus.src_tag].done) begin
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (bus.cdb_valid[p]
                    && bus.cdb_tag[p] == bus.src_tag) begin
                    bus.src_ready = 1'b1;
                    bus.src_data  = bus.cdb_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i].busy <= 1'b0;
                r_entry[i].done <= 1'b0;
            end
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (w_mask[k]) begin
                    r_entry[w_cidx[k]].busy <= 1'b0;
                    r_entry[w_cidx[k]].done <= 1'b0;
                end
            end
            // Descending order lets port 0 win a shared tag.
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (bus.cdb_valid[p]
                    && w_busy[bus.cdb_tag[p]]
                    && !w_done[bus.cdb_tag[p]]) begin
                    r_entry[bus.cdb_tag[p]].done <= 1'b1;
                    r_entry[bus.cdb_tag[p]].data <=
                        ROB_XLEN'(bus.cdb_data[p]);
                end
            end
            if (w_alloc_fire) begin
                r_entry[r_tail].busy <= 1'b1;
                r_entry[r_tail].done <= 1'b0;
                r_entry[r_tail].rd   <= bus.alloc_rd;
                r_tail <= IDX_W'(rob_ptr_add(
                    32'(r_tail), 32'd1, DEPTH));
            end
            r_head <= IDX_W'(rob_ptr_add(
                32'(r_head), 32'(w_ncommit), DEPTH));
            r_count <= r_count
                + (IDX_W+1)'(w_alloc_fire) - w_ncommit;
        end
    end

`ifdef ROB_PERF_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_commits;
    logic [31:0] r_perf_flushes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full    <= '0;
            r_perf_commits <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (bus.alloc_valid && !bus.alloc_ready) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
            r_perf_commits <= r_perf_commits + 32'(w_nretire);
            if (bus.flush) begin
                r_perf_flushes <= r_perf_flushes + 32'd1;
            end
        end
    end

    assign bus.perf_full_cycles = r_perf_full;
    assign bus.perf_commits     = r_perf_commits;
    assign bus.perf_flushes     = r_perf_flushes;
`endif
endmodule

// File: tb/tb_rob_multi_commit.sv
// Randomized + directed check of rob_multi_commit against
// an in-order queue model of the reorder buffer.
module tb_rob_multi_commit;
    import rob_pkg::*;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int CP    = 2;
    localparam int CW    = 2;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_multi_commit_if #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .CDB_PORTS(CP),
        .COMMIT_W(CW), .XLEN(XLEN)
    ) bus ();

    rob_multi_commit #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .CDB_PORTS(CP),
        .COMMIT_W(CW), .XLEN(XLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: in-flight tags in program order, per-tag state.
    int          q[$];
    int          m_tail;
    bit          m_done [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [31:0] m_data [DEPTH];
    logic [31:0] m_pf_full, m_pf_commits, m_pf_flushes;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int m_ncommit();
        int n = 0;
        if (bus.flush) return 0;
        while (n < CW && n < q.size() && m_done[q[n]]) n++;
        return n;
    endfunction

    function automatic bit m_busy(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        q.delete();
        m_tail = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_done[i] = 0;
            m_rd[i]   = '0;
            m_data[i] = '0;
        end
        m_pf_full    = '0;
        m_pf_commits = '0;
        m_pf_flushes = '0;
    endtask

    task automatic check_outputs();
        int nc = m_ncommit();
        int t;
        bit sr;
        logic [31:0] sd;
        chk("count", bus.count, q.size());
        chk("alloc_ready", bus.alloc_ready, q.size() != DEPTH);
        chk("alloc_tag", bus.alloc_tag, m_tail);
        for (int k = 0; k < CW; k++) begin
            chk("commit_valid", bus.commit_valid[k], k < nc);
            if (k < nc) begin
                chk("commit_tag", bus.commit_tag[k], q[k]);
                chk("commit_rd", bus.commit_rd[k], m_rd[q[k]]);
                chk("commit_data", bus.commit_data[k],
                    m_data[q[k]]);
                chk("commit_we", bus.commit_we[k],
                    m_rd[q[k]] != 0);
            end else begin
                chk("commit_we_idle", bus.commit_we[k], 0);
            end
        end
        t  = int'(bus.src_tag);
        sr = 0;
        sd = '0;
        if (m_done[t]) begin
            sr = 1;
            sd = m_data[t];
        end else begin
            for (int p = 0; p < CP; p++) begin
                if (!sr && bus.cdb_valid[p]
                    && int'(bus.cdb_tag[p]) == t) begin
                    sr = 1;
                    sd = bus.cdb_data[p];
                end
            end
        end
        chk("src_ready", bus.src_ready, sr);
        if (sr) chk("src_data", bus.src_data, sd);
`ifdef ROB_PERF_EN
        chk("perf_full", bus.perf_full_cycles, m_pf_full);
        chk("perf_commits", bus.perf_commits, m_pf_commits);
        chk("perf_flushes", bus.perf_flushes, m_pf_flushes);
`endif
    endtask

    task automatic m_update();
        int  nc   = m_ncommit();
        int  sz   = q.size();
        bit  fire = bus.alloc_valid && sz != DEPTH;
        bit  cap [DEPTH];
        int  t;
        if (rst) begin
            m_reset();
            return;
        end
        if (bus.alloc_valid && sz == DEPTH) m_pf_full++;
        m_pf_commits += 32'(nc);
        if (bus.flush) begin
            m_pf_flushes++;
            q.delete();
            m_tail = 0;
            for (int i = 0; i < DEPTH; i++) m_done[i] = 0;
            return;
        end
        for (int i = 0; i < DEPTH; i++) cap[i] = 0;
        for (int p = 0; p < CP; p++) begin
            t = int'(bus.cdb_tag[p]);
            if (bus.cdb_valid[p] && m_busy(t)
                && !m_done[t] && !cap[t]) begin
                cap[t]    = 1;
                m_data[t] = bus.cdb_data[p];
            end
        end
        repeat (nc) begin
            m_done[q[0]] = 0;
            void'(q.pop_front());
        end
        for (int i = 0; i < DEPTH; i++) if (cap[i]) m_done[i] = 1;
        if (fire) begin
            q.push_back(m_tail);
            m_rd[m_tail]   = bus.alloc_rd;
            m_done[m_tail] = 0;
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic cyc();
        #2;
        check_outputs();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid = 1'b0;
        bus.alloc_rd    = '0;
        bus.cdb_valid   = '0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        bus.src_tag     = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd);
        idle();
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = rd;
        cyc();
    endtask

    task automatic cdb(input int p, input int t,
                       input logic [31:0] d);
        bus.cdb_valid[p] = 1'b1;
        bus.cdb_tag[p]   = IDX_W'(t);
        bus.cdb_data[p]  = d;
    endtask

    initial begin
        idle();
        m_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset outputs
        #2;
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_alloc_tag", bus.alloc_tag, 0);
        chk("rst_commit_valid", bus.commit_valid, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        cyc();

        // fill: 16 allocations, then a refused 17th
        for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1));
        alloc(5'd17);
        chk("full_count", bus.count, 16);
        chk("full_ready", bus.alloc_ready, 0);
        chk("full_tag_wrap", bus.alloc_tag, 0);

        // tag1 on port1, tag0 on port0
        idle();
        cdb(1, 1, 32'h1111);
        cdb(0, 0, 32'h0000_AAAA);
        cyc();
        idle();
        bus.alloc_valid = 1'b1;
        cdb(0, 2, 32'h2222);
        #2;
        chk("dual_commit", bus.commit_valid, 2'b11);
        chk("full_while_commit", bus.alloc_ready, 0);
        cyc();
        idle();
        #2;
        chk("tag2_commit", bus.commit_valid, 2'b01);
        chk("tag2_tag", bus.commit_tag[0], 2);
        cyc();

        // drain tags 3..14, leaving head at 15
        for (int t = 3; t <= 14; t++) begin
            idle();
            cdb(0, t, $urandom);
            cyc();
        end
        idle();
        cyc();
        chk("head15_count", bus.count, 1);
        alloc(5'd0);
        idle();
        cdb(0, 15, 32'hF00D);
        cdb(1, 0, 32'h0BAD);
        cyc();
        idle();
        #2;
        chk("wrap_commit", bus.commit_valid, 2'b11);
        chk("wrap_tag0", bus.commit_tag[0], 15);
        chk("wrap_tag1", bus.commit_tag[1], 0);
        chk("wrap_we", bus.commit_we, 2'b01);
        cyc();
        chk("wrap_empty", bus.count, 0);
        chk("wrap_tail", bus.alloc_tag, 1);

        // flush with a CDB write in flight
        for (int i = 0; i < 5; i++) alloc(5'(i + 3));
        idle();
        bus.flush = 1'b1;
        cdb(0, 3, 32'h3333);
        #2;
        chk("flush_commit", bus.commit_valid, 0);
        cyc();
        idle();
        chk("flush_count", bus.count, 0);
        chk("flush_tag", bus.alloc_tag, 0);
        chk("flush_cv", bus.commit_valid, 0);

        // operand bypass from cdb port 1
        for (int i = 0; i < 5; i++) alloc(5'(i + 1));
        idle();
        bus.src_tag = IDX_W'(4);
        cdb(1, 4, 32'hDEAD_BEEF);
        #2;
        chk("byp_ready", bus.src_ready, 1);
        chk("byp_data", bus.src_data, 32'hDEAD_BEEF);
        cyc();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            bus.alloc_valid = ($urandom % 4) != 0;
            bus.alloc_rd    = 5'($urandom);
            for (int p = 0; p < CP; p++) begin
                if ($urandom % 2) begin
                    int t;
                    if (q.size() != 0 && ($urandom % 4) != 0)
                        t = q[$urandom % q.size()];
                    else
                        t = $urandom % DEPTH;
                    cdb(p, t, $urandom);
                end
            end
            bus.src_tag = IDX_W'($urandom);
            bus.flush   = ($urandom % 64) == 0;
            rst         = ($urandom % 500) == 0;
            cyc();
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
